adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

Clocked SPI responder emulating the 16-bit serial ADC at the far end of the ADC serial link. It sits on the device side of SCLK/CS/ADC_Din/ADC_Dout, captures each 16-bit control word from the master, and returns a 16-bit conversion word MSB-first. It is used as the bench/FPGA stand-in for the ADC and as a loopback target for the master interface.

## Interface
- FRAME_BITS, 16: bits per CS-low frame; the only supported value is 16.
- SYNC_STAGES, 2: flip-flop stages on SCLK, CS and ADC_Din before use.
- clk  in  1  system clock; must be at least 8× SCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  serial clock from master; idles low.
- CS  in  1  active-low chip select from master.
- ADC_Din  in  1  serial control bits from master, MSB first.
- ADC_Dout  out  1  serial conversion bits to master, MSB first.
- tx_data  in  16  conversion word offered for the next frame.
- tx_load  out  1  one-clk pulse: tx_data was latched for the frame now starting.
- rx_data  out  16  last correctly received control word.
- rx_valid  out  1  one-clk pulse: rx_data was updated.
- frame_err  out  1  one-clk pulse: frame ended with a bit count other than 16.
- busy  out  1  high while a frame is active (state ACTIVE).

## Operation
- SCLK, CS and ADC_Din pass through SYNC_STAGES flops. Rise/fall detection on the synchronized SCLK and CS uses one additional register.
- States:
  - IDLE: wait for a CS falling edge, then go to ACTIVE.
  - ACTIVE: shift bits until a CS rising edge, then go to IDLE.
  - WAIT_CS: entered from reset when the synchronized CS is low. Wait for CS high, then go to IDLE. This prevents joining a frame mid-stream.
- On a CS falling edge (IDLE→ACTIVE):
  - Latch tx_data into the tx shift register and pulse tx_load.
  - Clear the 5-bit bit counter.
  - Drive the shift-register MSB on ADC_Dout.
- SCLK rising edge in ACTIVE: shift the synchronized ADC_Din into the LSB of the rx shift register; bit counter +1, saturating at 31.
- SCLK falling edge in ACTIVE: shift the tx register left with 0 fill, so ADC_Dout presents the next bit. After the 16th falling edge, ADC_Dout is 0.
- On a CS rising edge in ACTIVE:
  - bit counter == 16: rx_data ← rx shift register, pulse rx_valid.
  - bit counter != 16 (short or long frame): pulse frame_err; rx_data is unchanged.
- ADC_Dout is 0 whenever not in ACTIVE. It is driven, not tri-stated.
- SCLK edges while CS is high are ignored.

## Timing
- Reset values: ADC_Dout 0, rx_data 0, tx_load 0, rx_valid 0, frame_err 0, busy 0. Shift registers and counter are 0. State is IDLE, or WAIT_CS per the first synchronized CS sample.
- Detection latency: SYNC_STAGES+1 clk from a pin transition to the internal edge strobe.
- ADC_Dout MSB is valid SYNC_STAGES+2 clk after CS falls; subsequent bits follow the same delay after each SCLK fall.
- SCLK high and low times must each be at least SYNC_STAGES+2 clk. The 8× clk ratio guarantees this for SYNC_STAGES=2.
- rx_valid and frame_err assert SYNC_STAGES+2 clk after CS rises.
- CS edge and SCLK edge detected in the same clk: the CS edge wins and the SCLK edge is dropped.
- CS fall detected in the same clk as the end of a frame: the ending frame completes first, and the new frame starts on the next detected CS fall.
- rst_n asserted mid-frame: outputs return to reset values immediately, and no pulses are emitted for the aborted frame.

## Configuration
- ADC_RESP_CHAN_TAG_EN defined:
  - The latched word is {1'b0, chan[2:0], tx_data[11:0]}.
  - chan is rx_data[12:10] of the previous valid frame, and 0 after reset.
- Not defined: the latched word is tx_data[15:0] unmodified.

## Structure
- Package adc_spi_pkg holds:
  - FRAME_BITS_DEF = 16.
  - The state enum: IDLE, ACTIVE, WAIT_CS.
  - CHAN_MSB = 12 and CHAN_LSB = 10.
- Sub-module adc_spi_sync, instantiated once per synchronized signal:
  - Contains the SYNC_STAGES flop chain plus the edge register.
  - Outputs level, rise and fall.

## Test plan
- Nominal frame, clk = 8× SCLK: master sends 16'hA5C3, tx_data = 16'h0FFF, tag off -> ADC_Dout bits equal 16'h0FFF MSB-first; rx_valid pulses once; rx_data = 16'hA5C3.
- Short frame: CS rises after 10 SCLK -> frame_err pulses; rx_valid stays low; rx_data holds its prior value.
- Long frame: 18 SCLK -> ADC_Dout is 0 for bits 17–18; frame_err pulses.
- Reset mid-frame with CS still low, then CS rises and a full frame follows -> no pulses during the aborted frame; next frame receives correctly.
- Channel tag (ADC_RESP_CHAN_TAG_EN): frame 1 rx 16'h1C00, frame 2 tx_data 16'hFABC -> frame 2 ADC_Dout word = 16'h7ABC.
- SCLK toggles 5 times with CS high -> no state change, ADC_Dout stays 0, no pulses.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared constants and state encoding for the ADC SPI responder.
package adc_spi_pkg;

  localparam int FRAME_BITS_DEF = 16;
  localparam int CHAN_MSB       = 12;
  localparam int CHAN_LSB       = 10;
  localparam int CNT_W          = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_CS = 2'd2
  } adc_state_e;

endpackage

// File: rtl/adc_spi_sync.sv
// Synchronizer chain for one asynchronous pin plus an edge register that
// yields single-clk rise/fall strobes on the synchronized level.
module adc_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 16-bit serial ADC: captures the master's control
// word, returns a conversion word MSB-first. Optional: ADC_RESP_CHAN_TAG_EN.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  ADC_Din,
  output logic                  ADC_Dout,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy,
  output adc_state_e            state_dbg
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic din_level, din_rise, din_fall;

  adc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CS chain resets low so the FSM waits in WAIT_CS until the first real
  // synchronized sample shows CS high; a frame already in progress is skipped.
  adc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(CS),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  adc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .d(ADC_Din),
    .level(din_level), .rise(din_rise), .fall(din_fall)
  );

  adc_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_sr, rx_sr, load_word;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   load_tx, shift_rx, shift_tx, end_ok, end_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_CS;
    else        state_q <= state_d;
  end

  // A CS edge takes priority: SCLK strobes in the same clk are dropped.
  always_comb begin
    state_d  = state_q;
    load_tx  = 1'b0;
    shift_rx = 1'b0;
    shift_tx = 1'b0;
    end_ok   = 1'b0;
    end_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          load_tx = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt == FRAME_CNT) end_ok  = 1'b1;
          else                      end_err = 1'b1;
        end else begin
          shift_rx = sclk_rise;
          shift_tx = sclk_fall;
        end
      end
      WAIT_CS: begin
        if (cs_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_RESP_CHAN_TAG_EN
  logic [CHAN_MSB-CHAN_LSB:0] chan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chan_q <= '0;
    else if (end_ok) chan_q <= rx_sr[CHAN_MSB:CHAN_LSB];
  end

  assign load_word = {1'b0, chan_q, tx_data[CHAN_MSB-1:0]};
`else
  assign load_word = tx_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      tx_load   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_load   <= load_tx;
      rx_valid  <= end_ok;
      frame_err <= end_err;
      if (load_tx) begin
        tx_sr   <= load_word;
        bit_cnt <= '0;
      end
      if (shift_rx) begin
        rx_sr <= {rx_sr[FRAME_BITS-2:0], din_level};
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_tx) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
      if (end_ok)   rx_data <= rx_sr;
    end
  end

  assign busy      = (state_q == ACTIVE);
  assign ADC_Dout  = busy & tx_sr[FRAME_BITS-1];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: table of frames, randomized
// frames against a word-level model, and hand-written corner sequences.
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic        ADC_Din = 1'b0;
  logic [15:0] tx_data = '0;
  logic        ADC_Dout, tx_load, rx_valid, frame_err, busy;
  logic [15:0] rx_data;
  adc_state_e  state_dbg;

  adc_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .CS(CS), .ADC_Din(ADC_Din),
    .ADC_Dout(ADC_Dout), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_err = 0, n_load = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_rx_data;
  logic [2:0]  m_chan;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_rx_data = '0;
    m_chan    = '0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_load)   n_load++;
      if (frame_err) n_err++;
      if (rx_valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
        else                   check("rx_data_at_valid", rx_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_word(input logic [15:0] tx);
`ifdef ADC_RESP_CHAN_TAG_EN
    return {1'b0, m_chan, tx[11:0]};
`else
    return tx;
`endif
  endfunction

  function automatic logic [31:0] model_miso(input int nbits, input logic [15:0] w);
    logic [31:0] v = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) v = {v[30:0], w[15-i]};
      else        v = {v[30:0], 1'b0};
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic run_frame(input int nbits, input logic [15:0] mosi, input logic [15:0] tx,
                           output logic [31:0] miso, output logic busy_seen);
    miso    = '0;
    tx_data = tx;
    ADC_Din = mosi[15];
    CS      = 1'b0;
    tick(HALF);
    busy_seen = busy;
    for (int i = 0; i < nbits; i++) begin
      miso = {miso[30:0], ADC_Dout};
      busy_seen &= busy;
      SCLK = 1'b1;
      tick(HALF);
      SCLK = 1'b0;
      if (i < 15) ADC_Din = mosi[14-i];
      else        ADC_Din = 1'($urandom_range(0, 1));
      tick(HALF);
    end
    CS = 1'b1;
    tick(8);
  endtask

  task automatic do_frame(input string name, input int nbits, input logic [15:0] mosi,
                          input logic [15:0] tx, input int exp_valid, input int exp_err,
                          output logic [31:0] miso);
    logic [15:0] w;
    logic        bs;
    int v0, e0, l0;
    w  = model_word(tx);
    v0 = n_valid; e0 = n_err; l0 = n_load;
    if (exp_valid != 0) exp_q.push_back(mosi);
    run_frame(nbits, mosi, tx, miso, bs);
    check({name, "_miso"}, miso, model_miso(nbits, w));
    check({name, "_busy"}, 32'(bs), 32'd1);
    check({name, "_tx_load"}, n_load - l0, 32'd1);
    check({name, "_rx_valid"}, n_valid - v0, exp_valid);
    check({name, "_frame_err"}, n_err - e0, exp_err);
    if (exp_valid != 0) begin
      m_rx_data = mosi;
      m_chan    = mosi[12:10];
    end
    check({name, "_rx_data"}, rx_data, m_rx_data);
    check({name, "_dout_idle"}, ADC_Dout, 1'b0);
  endtask

  typedef struct {
    int          nbits;
    logic [15:0] mosi;
    logic [15:0] tx;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[9];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] miso;
    int v0, e0, l0;

    vecs[0] = '{16, 16'hA5C3, 16'h0FFF, 1, 0};
    vecs[1] = '{10, 16'h1234, 16'h5555, 0, 1};
    vecs[2] = '{18, 16'h5A5A, 16'h8001, 0, 1};
    vecs[3] = '{16, 16'h1C00, 16'h1111, 1, 0};
    vecs[4] = '{16, 16'h0F0F, 16'hFABC, 1, 0};
    vecs[5] = '{0,  16'hFFFF, 16'hAAAA, 0, 1};
    vecs[6] = '{15, 16'h8000, 16'h7FFF, 0, 1};
    vecs[7] = '{17, 16'hFFFF, 16'hC3C3, 0, 1};
    vecs[8] = '{16, 16'h0000, 16'hFFFF, 1, 0};

    model_reset();
    tick(3);
    check("reset_dout", ADC_Dout, 1'b0);
    check("reset_rx_data", rx_data, 16'h0);
    check("reset_pulses", {tx_load, rx_valid, frame_err, busy}, 4'b0);
    rst_n = 1'b1;
    tick(6);
    check("post_reset_state", state_dbg, IDLE);

    for (int i = 0; i < 9; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].nbits, vecs[i].mosi, vecs[i].tx,
               vecs[i].exp_valid, vecs[i].exp_err, miso);
      if (i == 0) begin
        check("nominal_word", miso, 32'h0FFF);
        check("nominal_rx", rx_data, 16'hA5C3);
      end
      if (i == 1) check("short_rx_hold", rx_data, 16'hA5C3);
      if (i == 2) check("long_tail_zero", miso[1:0], 2'b00);
`ifdef ADC_RESP_CHAN_TAG_EN
      if (i == 4) check("chan_tag_word", miso, 32'h7ABC);
`else
      if (i == 4) check("untagged_word", miso, 32'hFABC);
`endif
    end

    // SCLK activity with CS high must be ignored.
    v0 = n_valid; e0 = n_err; l0 = n_load;
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b1;
      tick(HALF);
      check("cs_high_dout", ADC_Dout, 1'b0);
      SCLK = 1'b0;
      tick(HALF);
    end
    check("cs_high_state", state_dbg, IDLE);
    check("cs_high_pulses", (n_valid - v0) + (n_err - e0) + (n_load - l0), 32'd0);

    // CS rise detected with the 16th SCLK rise: that SCLK edge is dropped.
    v0 = n_valid; e0 = n_err;
    tx_data = 16'h1357;
    ADC_Din = 1'b1;
    CS = 1'b0;
    tick(HALF);
    for (int i = 0; i < 15; i++) begin
      SCLK = 1'b1; tick(HALF);
      SCLK = 1'b0; tick(HALF);
    end
    SCLK = 1'b1;
    CS = 1'b1;
    tick(HALF);
    SCLK = 1'b0;
    tick(8);
    check("cs_wins_err", n_err - e0, 32'd1);
    check("cs_wins_valid", n_valid - v0, 32'd0);

    // Reset mid-frame, released while CS is still low.
    tx_data = 16'hFFFF;
    ADC_Din = 1'b1;
    CS = 1'b0;
    tick(HALF);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b1; tick(HALF);
      SCLK = 1'b0; tick(HALF);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_dout", ADC_Dout, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 16'h0);
    model_reset();
    v0 = n_valid; e0 = n_err; l0 = n_load;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b1; tick(HALF);
      check("midrst_join_dout", ADC_Dout, 1'b0);
      SCLK = 1'b0; tick(HALF);
    end
    check("midrst_join_busy", busy, 1'b0);
    CS = 1'b1;
    tick(8);
    check("midrst_pulses", (n_valid - v0) + (n_err - e0) + (n_load - l0), 32'd0);
    check("midrst_state", state_dbg, IDLE);
    do_frame("after_rst", 16, 16'hC0DE, 16'hBEEF, 1, 0, miso);

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++) begin
      int          nb;
      logic [15:0] mo, tx;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      mo = 16'($urandom);
      tx = 16'($urandom);
      do_frame($sformatf("rnd%0d", i), nb, mo, tx, (nb == 16) ? 1 : 0,
               (nb == 16) ? 0 : 1, miso);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
